mips_multicycle_ctrl: RTL
=========================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have parameter EN_ADDI, default 1, meaning ADDI (opcode 0x08) is supported when 1 and illegal when 0.
REQ-002 SHALL have parameter EN_JUMP, default 1, meaning J (opcode 0x02) is supported when 1 and illegal when 0.
REQ-003 SHALL have parameter RET_W, default 16, meaning the width of the retired-instruction counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset; it is synchronous and active-low.
REQ-006 SHALL have port opcode, input, 6, instr[31:26] from the instruction register.
REQ-007 SHALL have port mem_ready, input, 1, memory handshake; 1 = access completes this cycle.
REQ-008 SHALL have outputs IorD, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA, RegDst, MemtoReg, RegWrite, 1 bit each, the multicycle datapath controls.
REQ-009 SHALL have outputs PCSrc, ALUSrcB and ALUOp, 2 bits each; ALUOp uses 00 add, 01 sub, 10 funct.
REQ-010 SHALL have output illegal_op, 1 bit, sticky unsupported-opcode flag.
REQ-011 SHALL have output retired, RET_W bits, count of completed instructions.

Function
REQ-012 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB and JUMP; outputs SHALL be decoded from the state only, except that mem_ready gates the enables named below.
REQ-013 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSrc=00; IRWrite=PCWrite=mem_ready; go to DECODE if mem_ready, else stay in FETCH.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=11 and ALUOp=00; next state is MEMADR for 0x23/0x2B, EXECUTE for 0x00, BRANCH for 0x04, ADDIEX for 0x08 (if EN_ADDI), JUMP for 0x02 (if EN_JUMP), otherwise FETCH.
REQ-015 MEMADR: ALUSrcA=1, ALUSrcB=10 and ALUOp=00; next state is MEMRD for 0x23 and MEMWR for 0x2B.
REQ-016 MEMRD: IorD=1; go to MEMWB when mem_ready, else stay.
REQ-017 MEMWB: RegDst=0, MemtoReg=1 and RegWrite=1; next state is FETCH.
REQ-018 MEMWR: IorD=1 and MemWrite=mem_ready; go to FETCH when mem_ready, else stay.
REQ-019 EXECUTE: ALUSrcA=1, ALUSrcB=00 and ALUOp=10, then go to ALUWB; ALUWB: RegDst=1, MemtoReg=0 and RegWrite=1, then go to FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1 and PCSrc=01; next state is FETCH.
REQ-021 ADDIEX: ALUSrcA=1, ALUSrcB=10 and ALUOp=00, then go to ADDIWB; ADDIWB: RegDst=0, MemtoReg=0 and RegWrite=1, then go to FETCH.
REQ-022 JUMP: PCSrc=10 and PCWrite=1; next state is FETCH.
REQ-023 Every output not listed for a state SHALL be 0; no output SHALL be X or latched.
REQ-024 An unsupported opcode in DECODE SHALL set illegal_op at the next edge; illegal_op SHALL hold until reset.
REQ-025 retired SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWR (with mem_ready=1), ALUWB, BRANCH, ADDIWB or JUMP, and SHALL wrap from all-ones to 0; an illegal opcode SHALL NOT increment it.

Reset
REQ-026 While rst_n=0 at a rising edge, the FSM SHALL go to FETCH, retired SHALL become 0 and illegal_op SHALL become 0, from any state including mid-access.
REQ-027 While rst_n=0, IRWrite, PCWrite, MemWrite and RegWrite SHALL be forced to 0 combinationally.

Structure
REQ-028 State encoding, opcode constants (0x00, 0x02, 0x04, 0x08, 0x23, 0x2B) and ALUOp codes SHALL live in a shared package, mips_ctrl_pkg.
REQ-029 The state-to-output decoding SHALL be a single combinational sub-module, mctrl_out_decode.

Verification
REQ-030 Opcode 0x23 with mem_ready=1 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB (5 cycles); in cycle 5 RegWrite=1, MemtoReg=1 and RegDst=0; retired goes 0->1.
REQ-031 Opcode 0x2B with mem_ready low for 2 cycles in MEMWR -> MemWrite=1 only in the 3rd MEMWR cycle; total 6 cycles.
REQ-032 Opcode 0x04 -> 3 cycles; in BRANCH, Branch=1, PCSrc=01 and ALUOp=01; opcode 0x00 -> 4 cycles with ALUOp=10 in EXECUTE.
REQ-033 mem_ready=0 for 3 cycles in FETCH -> FETCH held 4 cycles; IRWrite and PCWrite are 1 only in the 4th cycle.
REQ-034 Opcode 0x3F, and opcode 0x02 with EN_JUMP=0 -> DECODE to FETCH; illegal_op=1 and sticky; retired unchanged.
REQ-035 rst_n=0 during MEMRD -> FETCH next cycle, retired=0, all write enables 0 during reset; with RET_W=2, 4 retirements make retired wrap to 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcode constants, datapath select codes and the opcode legality check.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    // Opcodes the controller can sequence, given the optional instructions enabled.
    function automatic logic op_supported(input logic [5:0] op,
                                          input logic en_addi,
                                          input logic en_jump);
        logic ok;
        case (op)
            OP_RTYPE, OP_BEQ, OP_LW, OP_SW: ok = 1'b1;
            OP_ADDI:                        ok = en_addi;
            OP_J:                           ok = en_jump;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mctrl_out_decode.sv
// Moore output decoder for the multicycle controller; mem_ready only gates
// the memory-handshake enables and reset forces every write enable low.
import mips_ctrl_pkg::*;

module mctrl_out_decode (
    input  state_e     state,
    input  logic       mem_ready,
    input  logic       rst_n,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       ALUSrcA,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp
);

    logic mem_write_s;
    logic ir_write_s;
    logic pc_write_s;
    logic reg_write_s;

    // Per-state datapath control decode.
    always_comb begin
        IorD        = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        Branch      = 1'b0;
        ALUSrcA     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        reg_write_s = 1'b0;
        PCSrc       = PCSRC_ALU;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcB    = SRCB_FOUR;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_BOFF;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                IorD = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg    = 1'b1;
                reg_write_s = 1'b1;
            end
            S_MEMWR: begin
                IorD        = 1'b1;
                mem_write_s = mem_ready;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst      = 1'b1;
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_SUB;
                Branch  = 1'b1;
                PCSrc   = PCSRC_ALUOUT;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
            end
            S_JUMP: begin
                PCSrc      = PCSRC_JUMP;
                pc_write_s = 1'b1;
            end
            default: begin
                IorD = 1'b0;
            end
        endcase
    end

    // Architectural write enables must be dead while reset is held.
    always_comb begin
        MemWrite = mem_write_s & rst_n;
        IRWrite  = ir_write_s  & rst_n;
        PCWrite  = pc_write_s  & rst_n;
        RegWrite = reg_write_s & rst_n;
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory handshake, sticky illegal-opcode
// flag and a wrapping retired-instruction counter.
import mips_ctrl_pkg::*;

module mips_multicycle_ctrl #(
    parameter int EN_ADDI = 1,
    parameter int EN_JUMP = 1,
    parameter int RET_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic             ALUSrcA,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic [1:0]       PCSrc,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             illegal_op,
    output logic [RET_W-1:0] retired
);

    localparam logic ADDI_ON = (EN_ADDI != 0);
    localparam logic JUMP_ON = (EN_JUMP != 0);
    localparam logic [RET_W-1:0] RET_ONE = {{(RET_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [RET_W-1:0] retired_q, retired_d;
    logic             retire_s;

    // State, sticky flag and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= {RET_W{1'b0}};
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (!op_supported(opcode, ADDI_ON, JUMP_ON)) begin
                    state_d = S_FETCH;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXECUTE;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // An instruction retires on the completing transition back to FETCH;
    // DECODE->FETCH (illegal opcode) is deliberately excluded.
    always_comb begin
        retire_s  = 1'b0;
        illegal_d = illegal_q;
        if (state_d == S_FETCH) begin
            case (state_q)
                S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire_s = 1'b1;
                default:                                               retire_s = 1'b0;
            endcase
        end else begin
            retire_s = 1'b0;
        end
        if ((state_q == S_DECODE) && !op_supported(opcode, ADDI_ON, JUMP_ON)) begin
            illegal_d = 1'b1;
        end else begin
            illegal_d = illegal_q;
        end
        retired_d = retire_s ? (retired_q + RET_ONE) : retired_q;
    end

    mctrl_out_decode u_out_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .rst_n     (rst_n),
        .IorD      (IorD),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .Branch    (Branch),
        .ALUSrcA   (ALUSrcA),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .PCSrc     (PCSrc),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp)
    );

    assign illegal_op = illegal_q;
    assign retired    = retired_q;

endmodule
